// File: rtl/pifo_pkg.sv
// Shared types and constants for the PIFO scheduler and its enqueue-side front end.
package pifo_pkg;

  localparam int FLOW_W   = 2;
  localparam int SHIFT_W  = 4;
  localparam int LEN_W    = 16;

  typedef logic [31:0]       rank_t;
  typedef logic [31:0]       value_t;
  typedef logic [FLOW_W-1:0] flow_id_t;

  localparam rank_t RANK_MAX = 32'hFFFF_FFFF;

  // Unsigned add that clamps to RANK_MAX instead of wrapping.
  function automatic rank_t sat_add(input rank_t a, input rank_t b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? RANK_MAX : sum[31:0];
  endfunction

  // Larger of two unsigned ranks.
  function automatic rank_t rank_max(input rank_t a, input rank_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/stfq_flow_table.sv
// Per-flow finish tags and weight shifts for the STFQ rank computer.
// Table is sized to the full flow-ID space; IDs at or above NUM_FLOWS
// are never written, so they read back as zero.
module stfq_flow_table
  import pifo_pkg::*;
#(
  parameter int NUM_FLOWS = 4,
  parameter int FLOW_W    = $clog2(NUM_FLOWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOW_W-1:0]  rd_flow,
  output rank_t              rd_finish,
  output logic [SHIFT_W-1:0] rd_shift,
  input  logic               fin_we,
  input  logic [FLOW_W-1:0]  fin_flow,
  input  rank_t              fin_data,
  input  logic               cfg_we,
  input  logic [FLOW_W-1:0]  cfg_flow,
  input  logic [SHIFT_W-1:0] cfg_shift
);

  localparam int TABLE_SIZE = 1 << FLOW_W;

  rank_t              finish_q [TABLE_SIZE];
  logic [SHIFT_W-1:0] shift_q  [TABLE_SIZE];
  logic               fin_ok;
  logic               cfg_ok;

  // Out-of-range IDs only exist when NUM_FLOWS is not a power of two.
  generate
    if (NUM_FLOWS == TABLE_SIZE) begin : g_full
      assign fin_ok = 1'b1;
      assign cfg_ok = 1'b1;
    end else begin : g_partial
      assign fin_ok = ({1'b0, fin_flow} < (FLOW_W+1)'(NUM_FLOWS));
      assign cfg_ok = ({1'b0, cfg_flow} < (FLOW_W+1)'(NUM_FLOWS));
    end
  endgenerate

  assign rd_finish = finish_q[rd_flow];
  assign rd_shift  = shift_q[rd_flow];

  // Finish and shift writes are independent, so both may land in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        finish_q[i] <= '0;
        shift_q[i]  <= '0;
      end
    end else begin
      if (fin_we && fin_ok) finish_q[fin_flow] <= fin_data;
      if (cfg_we && cfg_ok) shift_q[cfg_flow]  <= cfg_shift;
    end
  end

endmodule

// File: rtl/stfq_rank_computer.sv
// Enqueue-side front end for the PIFO scheduler: assigns each accepted
// packet a Start-Time Fair Queuing rank, pushes it to the scheduler and
// tracks scheduler occupancy with a credit counter.
module stfq_rank_computer
  import pifo_pkg::*;
#(
  parameter int NUM_FLOWS = 4,
  parameter int FLOW_W    = $clog2(NUM_FLOWS),
  parameter int DEPTH     = 10,
  parameter int OCC_W     = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOW_W-1:0]  in_flow,
  input  logic [LEN_W-1:0]   in_len,
  input  value_t             in_value,
  input  logic               cfg_we,
  input  logic [FLOW_W-1:0]  cfg_flow,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               push,
  output rank_t              push_rank,
  output value_t             push_value,
  input  logic               deq_valid,
  input  rank_t              deq_tag,
  output logic [OCC_W-1:0]   occupancy,
  output logic               err_underflow
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  rank_t              vt;
  rank_t              rd_finish;
  logic [SHIFT_W-1:0] rd_shift;
  logic               accept;
  logic               deq_ok;
  rank_t              inc;
  rank_t              start_tag;
  rank_t              new_finish;

  stfq_flow_table #(
    .NUM_FLOWS (NUM_FLOWS),
    .FLOW_W    (FLOW_W)
  ) u_flow_table (
    .clk       (clk),
    .rst       (rst),
    .rd_flow   (in_flow),
    .rd_finish (rd_finish),
    .rd_shift  (rd_shift),
    .fin_we    (accept),
    .fin_flow  (in_flow),
    .fin_data  (new_finish),
    .cfg_we    (cfg_we),
    .cfg_flow  (cfg_flow),
    .cfg_shift (cfg_shift)
  );

  assign in_ready = (occupancy < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign deq_ok   = deq_valid && (occupancy != '0);

  // Rank math uses the pre-edge vt and shift, so same-cycle dequeues and
  // config writes only influence packets accepted later.
  always_comb begin
    inc        = {16'b0, in_len >> rd_shift};
    start_tag  = rank_max(vt, rd_finish);
    new_finish = sat_add(start_tag, inc);
  end

  // Push register, virtual time, credit counter and sticky underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push          <= 1'b0;
      push_rank     <= '0;
      push_value    <= '0;
      vt            <= '0;
      occupancy     <= '0;
      err_underflow <= 1'b0;
    end else begin
      push <= accept;
      if (accept) begin
        push_rank  <= start_tag;
        push_value <= in_value;
      end
      if (deq_ok && (deq_tag > vt)) vt <= deq_tag;
      case ({accept, deq_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (deq_valid && (occupancy == '0)) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stfq_rank_computer.sv
// Directed-vector bench for stfq_rank_computer with hand-computed ranks.
module tb_stfq_rank_computer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_flow;
  logic [15:0] in_len;
  logic [31:0] in_value;
  logic        cfg_we;
  logic [1:0]  cfg_flow;
  logic [3:0]  cfg_shift;
  logic        push;
  logic [31:0] push_rank;
  logic [31:0] push_value;
  logic        deq_valid;
  logic [31:0] deq_tag;
  logic [3:0]  occupancy;
  logic        err_underflow;

  int vectors;
  int miscompares;

  stfq_rank_computer #(
    .NUM_FLOWS (4),
    .DEPTH     (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flow       (in_flow),
    .in_len        (in_len),
    .in_value      (in_value),
    .cfg_we        (cfg_we),
    .cfg_flow      (cfg_flow),
    .cfg_shift     (cfg_shift),
    .push          (push),
    .push_rank     (push_rank),
    .push_value    (push_value),
    .deq_valid     (deq_valid),
    .deq_tag       (deq_tag),
    .occupancy     (occupancy),
    .err_underflow (err_underflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 ns after it.
  task automatic applyStimulus(input logic v, input logic [1:0] f, input logic [15:0] len,
                               input logic [31:0] val, input logic dv, input logic [31:0] dtag,
                               input logic cw, input logic [1:0] cf, input logic [3:0] cs);
    in_valid  = v;
    in_flow   = f;
    in_len    = len;
    in_value  = val;
    deq_valid = dv;
    deq_tag   = dtag;
    cfg_we    = cw;
    cfg_flow  = cf;
    cfg_shift = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic sendPkt(input logic [1:0] f, input logic [15:0] len, input logic [31:0] val);
    applyStimulus(1'b1, f, len, val, 1'b0, 32'h0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic deqTag(input logic [31:0] tag);
    applyStimulus(1'b0, 2'd0, 16'd0, 32'h0, 1'b1, tag, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic cfgShift(input logic [1:0] f, input logic [3:0] s);
    applyStimulus(1'b0, 2'd0, 16'd0, 32'h0, 1'b0, 32'h0, 1'b1, f, s);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'd0, 16'd0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    idleCycle();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_flow     = '0;
    in_len      = '0;
    in_value    = '0;
    cfg_we      = 1'b0;
    cfg_flow    = '0;
    cfg_shift   = '0;
    deq_valid   = 1'b0;
    deq_tag     = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_push",  32'(push), 32'd0);
    checkOutput("rst_rank",  push_rank, 32'd0);
    checkOutput("rst_value", push_value, 32'd0);
    checkOutput("rst_occ",   32'(occupancy), 32'd0);
    checkOutput("rst_err",   32'(err_underflow), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(in_ready), 32'd1);

    // Back-to-back packets on one flow.
    cfgShift(2'd0, 4'd0);
    sendPkt(2'd0, 16'd100, 32'hA0);
    checkOutput("b2b_push0",  32'(push), 32'd1);
    checkOutput("b2b_rank0",  push_rank, 32'd0);
    checkOutput("b2b_value0", push_value, 32'hA0);
    sendPkt(2'd0, 16'd100, 32'hA1);
    checkOutput("b2b_push1",  32'(push), 32'd1);
    checkOutput("b2b_rank1",  push_rank, 32'd100);
    checkOutput("b2b_value1", push_value, 32'hA1);
    checkOutput("b2b_occ",    32'(occupancy), 32'd2);
    checkOutput("b2b_ready",  32'(in_ready), 32'd1);
    idleCycle();
    checkOutput("idle_push", 32'(push), 32'd0);
    checkOutput("idle_rank", push_rank, 32'd100);

    // Weighted flows interleaved.
    cfgShift(2'd1, 4'd1);
    cfgShift(2'd2, 4'd0);
    sendPkt(2'd1, 16'd200, 32'hB0);
    checkOutput("w_f1_r0", push_rank, 32'd0);
    sendPkt(2'd2, 16'd200, 32'hC0);
    checkOutput("w_f2_r0", push_rank, 32'd0);
    sendPkt(2'd1, 16'd200, 32'hB1);
    checkOutput("w_f1_r1", push_rank, 32'd100);
    sendPkt(2'd2, 16'd200, 32'hC1);
    checkOutput("w_f2_r1", push_rank, 32'd200);
    checkOutput("w_occ", 32'(occupancy), 32'd6);

    // Fill to capacity; flow0 finish is 200 and len 0 keeps it there.
    for (int i = 0; i < 4; i++) begin
      sendPkt(2'd0, 16'd0, 32'hD0 + 32'(i));
      checkOutput("fill_rank", push_rank, 32'd200);
    end
    checkOutput("full_occ",   32'(occupancy), 32'd10);
    checkOutput("full_ready", 32'(in_ready), 32'd0);
    sendPkt(2'd0, 16'd50, 32'hEE);
    checkOutput("full_push",  32'(push), 32'd0);
    checkOutput("full_value", push_value, 32'hD3);
    checkOutput("full_occ2",  32'(occupancy), 32'd10);
    deqTag(32'd0);
    checkOutput("deq_ready", 32'(in_ready), 32'd1);
    checkOutput("deq_occ",   32'(occupancy), 32'd9);

    // Virtual time advance from the dequeue side.
    deqTag(32'd500);
    sendPkt(2'd3, 16'd10, 32'hF0);
    checkOutput("vt_f3_r0", push_rank, 32'd500);
    sendPkt(2'd3, 16'd10, 32'hF1);
    checkOutput("vt_f3_r1", push_rank, 32'd510);
    checkOutput("vt_occ",   32'(occupancy), 32'd10);

    // Same-cycle accept and dequeue, monotonic vt, same-cycle cfg write.
    doReset();
    sendPkt(2'd0, 16'd100, 32'h10);
    sendPkt(2'd0, 16'd100, 32'h11);
    sendPkt(2'd0, 16'd100, 32'h12);
    checkOutput("sc_pre_rank", push_rank, 32'd200);
    checkOutput("sc_pre_occ",  32'(occupancy), 32'd3);
    applyStimulus(1'b1, 2'd2, 16'd100, 32'h20, 1'b1, 32'd50, 1'b0, 2'd0, 4'd0);
    checkOutput("sc_rank_oldvt", push_rank, 32'd0);
    checkOutput("sc_occ",        32'(occupancy), 32'd3);
    sendPkt(2'd3, 16'd10, 32'h30);
    checkOutput("sc_rank_newvt", push_rank, 32'd50);
    deqTag(32'd40);
    sendPkt(2'd1, 16'd10, 32'h40);
    checkOutput("vt_no_decrease", push_rank, 32'd50);
    checkOutput("sc_occ2", 32'(occupancy), 32'd4);
    applyStimulus(1'b1, 2'd0, 16'd100, 32'h50, 1'b0, 32'h0, 1'b1, 2'd0, 4'd2);
    checkOutput("cfg_same_r0", push_rank, 32'd300);
    sendPkt(2'd0, 16'd100, 32'h51);
    checkOutput("cfg_same_r1", push_rank, 32'd400);
    sendPkt(2'd0, 16'd100, 32'h52);
    checkOutput("cfg_same_r2", push_rank, 32'd425);
    checkOutput("cfg_occ", 32'(occupancy), 32'd7);

    // Drain, then underflow.
    for (int i = 0; i < 7; i++) deqTag(32'd0);
    checkOutput("drain_occ", 32'(occupancy), 32'd0);
    checkOutput("drain_err", 32'(err_underflow), 32'd0);
    deqTag(32'd1000);
    checkOutput("uf_err", 32'(err_underflow), 32'd1);
    checkOutput("uf_occ", 32'(occupancy), 32'd0);
    sendPkt(2'd2, 16'd0, 32'h60);
    checkOutput("uf_vt_held", push_rank, 32'd100);
    checkOutput("uf_sticky",  32'(err_underflow), 32'd1);

    // Asynchronous reset mid-stream clears the pending push at once.
    sendPkt(2'd0, 16'd10, 32'h70);
    checkOutput("mid_push_pre", 32'(push), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_push",  32'(push), 32'd0);
    checkOutput("mid_rank",  push_rank, 32'd0);
    checkOutput("mid_value", push_value, 32'd0);
    checkOutput("mid_occ",   32'(occupancy), 32'd0);
    checkOutput("mid_err",   32'(err_underflow), 32'd0);
    idleCycle();
    rst = 1'b1;
    #1;
    checkOutput("mid_ready", 32'(in_ready), 32'd1);

    // Finish tag saturation near the top of the rank space.
    sendPkt(2'd0, 16'd0, 32'h80);
    deqTag(32'hFFFF_FFF0);
    sendPkt(2'd1, 16'hFFFF, 32'h81);
    checkOutput("sat_r0", push_rank, 32'hFFFF_FFF0);
    sendPkt(2'd1, 16'd5, 32'h82);
    checkOutput("sat_r1", push_rank, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
